// File: rtl/mul_pkg.sv
// Shared constants and control-bundle layout for the shift-add multiplier (FSM + datapath).
// Pure declarations: no latency, no flow control.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  // Iteration counter width; kept at least 1 bit so degenerate widths still elaborate.
  function automatic int mul_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Control bundle driven by the multiply FSM, MSB first.
  typedef struct packed {
    logic initialize;
    logic clear_c;
    logic load;
    logic shift_dec;
  } mul_ctrl_t;

  localparam int MUL_CTRL_W = $bits(mul_ctrl_t);

endpackage

// File: rtl/mul_adder.sv
// WIDTH-bit combinational adder with carry-out for the accumulate step.
// Zero latency, no flow control; swap for a faster adder without touching the datapath.
module mul_adder
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath (B, A, C, Q, P) with registered 2*WIDTH product; product is
// valid 2*WIDTH+1 cycles after initialize. No backpressure: product holds until next initialize.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = mul_cnt_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 initialize,
  input  logic                 clear_c,
  input  logic                 load,
  input  logic                 shift_dec,
  input  logic                 done,
  output logic                 q0,
  output logic                 z,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid
);

  mul_ctrl_t          w_ctrl;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_q;
  logic               r_c;
  logic [CNT_W-1:0]   r_p;
  logic [2*WIDTH-1:0] r_product;
  logic               r_product_valid;

  assign w_ctrl = {initialize, clear_c, load, shift_dec};

  mul_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Priority initialize > load > shift_dec; load+shift_dec together behaves as load alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_q <= '0;
      r_p <= '0;
    end else if (w_ctrl.initialize) begin
      r_b <= multiplicand;
      r_q <= multiplier;
      r_a <= '0;
      r_p <= CNT_W'(WIDTH - 1);
    end else if (w_ctrl.load) begin
      r_a <= w_sum;
    end else if (w_ctrl.shift_dec) begin
      r_a <= {r_c, r_a[WIDTH-1:1]};
      r_q <= {r_a[0], r_q[WIDTH-1:1]};
      r_p <= (r_p == '0) ? '0 : r_p - CNT_W'(1);
    end
  end

  // Carry from an add beats a simultaneous clear_c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c <= 1'b0;
    end else if (w_ctrl.initialize) begin
      if (w_ctrl.clear_c) begin
        r_c <= 1'b0;
      end
    end else if (w_ctrl.load) begin
      r_c <= w_cout;
    end else if (w_ctrl.shift_dec || w_ctrl.clear_c) begin
      r_c <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product       <= '0;
      r_product_valid <= 1'b0;
    end else begin
      if (done) begin
        r_product       <= {r_a, r_q};
        r_product_valid <= 1'b1;
      end
      if (w_ctrl.initialize) begin
        r_product_valid <= 1'b0;
      end
    end
  end

  assign q0            = r_q[0];
  assign z             = (r_p == '0);
  assign product       = r_product;
  assign product_valid = r_product_valid;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath at WIDTH=8, driving it with a behavioural multiply FSM.
module tb_mul_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           initialize;
  logic           clear_c;
  logic           load;
  logic           shift_dec;
  logic           done;
  logic           q0;
  logic           z;
  logic [2*W-1:0] product;
  logic           product_valid;

  int n_checks = 0;
  int n_pass   = 0;

  mul_datapath #(
    .WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .initialize    (initialize),
    .clear_c       (clear_c),
    .load          (load),
    .shift_dec     (shift_dec),
    .done          (done),
    .q0            (q0),
    .z             (z),
    .product       (product),
    .product_valid (product_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             exp_c;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply as the control FSM would sequence it: MUL0 (load on Q0, else clear C),
  // MUL1 (shift, leave on z), then a done cycle. exp_c < 0 means carry activity is not checked.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] prev, input logic [2*W-1:0] exp, input int exp_c);
    int lat = 0, shifts = 0, loads = 0, hold_bad = 0, a7_bad = 0, cseen = 0;
    bit zhit = 1'b0;
    bit pc;
    multiplicand = a;
    multiplier   = b;
    initialize   = 1'b1;
    tick();
    initialize = 1'b0;
    if (product_valid !== 1'b0 || product !== prev) hold_bad++;
    for (int i = 0; i < 2 * W + 4 && !zhit; i++) begin
      load    = q0;
      clear_c = !q0;
      if (q0) loads++;
      tick();
      lat++;
      load    = 1'b0;
      clear_c = 1'b0;
      if (product_valid !== 1'b0 || product !== prev) hold_bad++;
      pc = dut.r_c;
      if (pc) cseen = 1;
      zhit      = z;
      shift_dec = 1'b1;
      tick();
      lat++;
      shift_dec = 1'b0;
      shifts++;
      if (pc && dut.r_a[W-1] !== 1'b1) a7_bad++;
      if (product_valid !== 1'b0 || product !== prev) hold_bad++;
    end
    done = 1'b1;
    tick();
    lat++;
    done = 1'b0;
    check({tag, ".product"}, 32'(product), 32'(exp));
    check({tag, ".valid"}, 32'(product_valid), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(2 * W + 1));
    check({tag, ".shifts"}, 32'(shifts), 32'(W));
    check({tag, ".loads"}, 32'(loads), 32'($countones(b)));
    check({tag, ".hold"}, 32'(hold_bad), 32'd0);
    check({tag, ".c_into_a7"}, 32'(a7_bad), 32'd0);
    if (exp_c >= 0) check({tag, ".carry_seen"}, 32'(cseen), 32'(exp_c));
  endtask

  vec_t           vecs[5];
  logic [2*W-1:0] prev;
  logic [W-1:0]   ra, rb;

  initial begin
    rst          = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    initialize   = 1'b0;
    clear_c      = 1'b0;
    load         = 1'b0;
    shift_dec    = 1'b0;
    done         = 1'b0;

    vecs[0] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01, exp_c: 1};
    vecs[1] = '{a: 8'd0,   b: 8'd200, exp: 16'h0000, exp_c: 0};
    vecs[2] = '{a: 8'd200, b: 8'd0,   exp: 16'h0000, exp_c: 0};
    vecs[3] = '{a: 8'd13,  b: 8'd11,  exp: 16'h008F, exp_c: 0};
    vecs[4] = '{a: 8'd7,   b: 8'd6,   exp: 16'h002A, exp_c: 0};

    #12;
    check("rst.product", 32'(product), 32'd0);
    check("rst.valid", 32'(product_valid), 32'd0);
    check("rst.z", 32'(z), 32'd1);
    check("rst.q0", 32'(q0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    prev = '0;
    for (int i = 0; i < 5; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, prev, vecs[i].exp, vecs[i].exp_c);
      prev = vecs[i].exp;
    end

    // Reset between clock edges in the middle of a multiply.
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    initialize   = 1'b1;
    tick();
    initialize = 1'b0;
    load       = 1'b1;
    tick();
    load      = 1'b0;
    shift_dec = 1'b1;
    tick();
    shift_dec = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst.product", 32'(product), 32'd0);
    check("midrst.valid", 32'(product_valid), 32'd0);
    check("midrst.z", 32'(z), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_mul("post_rst", 8'd3, 8'd5, 16'd0, 16'd15, -1);
    prev = 16'd15;

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_mul($sformatf("rand%0d_%0dx%0d", i, ra, rb), ra, rb, prev, 16'(ra) * 16'(rb), -1);
      prev = 16'(ra) * 16'(rb);
    end

    // load together with shift_dec acts as load only.
    multiplicand = 8'd9;
    multiplier   = 8'hA5;
    initialize   = 1'b1;
    tick();
    initialize = 1'b0;
    load       = 1'b1;
    shift_dec  = 1'b1;
    tick();
    load      = 1'b0;
    shift_dec = 1'b0;
    check("ld_sh.a", 32'(dut.r_a), 32'd9);
    check("ld_sh.p", 32'(dut.r_p), 32'd7);
    check("ld_sh.q", 32'(dut.r_q), 32'hA5);
    check("ld_sh.c", 32'(dut.r_c), 32'd0);

    // Build A=0xF8 with B=0x10: 0x10 >> 1 = 0x08, then fifteen adds of 0x10.
    multiplicand = 8'h10;
    multiplier   = 8'h00;
    initialize   = 1'b1;
    tick();
    initialize = 1'b0;
    load       = 1'b1;
    tick();
    load      = 1'b0;
    shift_dec = 1'b1;
    tick();
    shift_dec = 1'b0;
    load      = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    load = 1'b0;
    check("pre_ldc.a", 32'(dut.r_a), 32'hF8);
    load    = 1'b1;
    clear_c = 1'b1;
    tick();
    load    = 1'b0;
    clear_c = 1'b0;
    check("ld_clr.c", 32'(dut.r_c), 32'd1);
    check("ld_clr.a", 32'(dut.r_a), 32'h08);
    tick();
    check("idle.c", 32'(dut.r_c), 32'd1);
    check("idle.a", 32'(dut.r_a), 32'h08);

    // Counter saturates at zero under extra shifts.
    shift_dec = 1'b1;
    for (int i = 0; i < W + 2; i++) tick();
    shift_dec = 1'b0;
    check("sat.p", 32'(dut.r_p), 32'd0);
    check("sat.z", 32'(z), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
Shift-add multiplier datapath driven by the multiply control FSM. It holds the multiplicand (B), accumulator (A), carry (C), multiplier/low-product (Q) and iteration counter (P). It returns the Q0 and z status bits to the FSM and presents a registered 2*WIDTH product with a valid flag to the integer execute stage.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
CNT_W, $clog2(WIDTH), width of iteration counter P.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-high reset.
multiplicand  in  WIDTH  operand captured into B on initialize.
multiplier  in  WIDTH  operand captured into Q on initialize.
initialize  in  1  FSM: load operands, clear A, preset P.
clear_c  in  1  FSM: clear carry C.
load  in  1  FSM: {C,A} <= A + B.
shift_dec  in  1  FSM: shift {C,A,Q} right 1, decrement P.
done  in  1  FSM: one-cycle completion pulse.
q0  out  1  Q[0], combinational, to FSM Q0 input.
z  out  1  (P == 0), combinational, to FSM z input.
product  out  2*WIDTH  registered result.
product_valid  out  1  result in product is valid.

Behaviour:
- Reset: while rst is high, asynchronously clear A, B, Q, C, product and product_valid to 0 and set P to 0. q0=0 and z=1 during and after reset. Reset mid-operation discards all state; no partial product appears.
- All register updates occur on posedge clk. Control inputs are level-sampled.
- Priority within one cycle, highest first: initialize, load, shift_dec.
  - load with shift_dec is illegal. load wins and shift_dec is ignored; no assertion is required.
  - clear_c combines freely with the others.
- initialize: B<=multiplicand, Q<=multiplier, A<=0, P<=WIDTH-1, product_valid<=0. product holds its old value.
- clear_c: C<=0. When clear_c coincides with load, the carry from load wins.
- load: {C,A} <= {1'b0,A} + {1'b0,B}, a WIDTH+1-bit add. B, Q and P are unchanged.
- shift_dec:
  - Shift: A<={C,A[WIDTH-1:1]}, Q<={A[0],Q[WIDTH-1:1]}, C<=0.
  - Count: P<=P-1, saturating at 0 with no wrap.
- z timing: z is high during the final MUL1 cycle, so the FSM exits to IDLE on the same edge that performs the last shift. Exactly WIDTH shift_dec pulses follow one initialize.
- done: on the edge where done=1, product<={A,Q} and product_valid<=1. The FSM raises done the cycle after the final shift, so {A,Q} already holds the full product. product_valid stays high until the next initialize or rst.
- Arithmetic is unsigned. Full 2*WIDTH result, no overflow possible.
- Latency from initialize edge to product_valid: 2*WIDTH+1 cycles for any operands. The FSM spends 2 cycles per bit.
- No control asserted: all registers hold.

Decomposition:
- Shared package mul_pkg holds:
  - the WIDTH default;
  - the CNT_W derivation;
  - the 4-bit control-bundle ordering {initialize, clear_c, load, shift_dec}, shared with the FSM.
- One sub-module, mul_adder: WIDTH-bit combinational adder with carry-out, used for load. It is swappable for a faster adder later.
- All registers live in mul_datapath.

Test Plan:
- WIDTH=8, multiplicand=13, multiplier=11, FSM-driven -> product=143 (0x008F), product_valid rises exactly 17 cycles after the initialize edge, z asserts only in the final MUL1 cycle.
- WIDTH=8, 255*255 -> product=65025 (0xFE01). C=1 is observed after the load steps that overflow A and is shifted into A[7].
- WIDTH=8, 0*200 and 200*0 -> product=0. q0 tracks the multiplier LSBs and no load pulses occur for the 0 multiplier.
- Second initialize (7*6) while product_valid=1 from a prior 143 result -> product_valid drops next cycle, product holds 143 until done, then becomes 42.
- rst asserted mid-computation between posedges -> outputs clear immediately (product=0, product_valid=0, z=1). A fresh 3*5 completes to 15.
- Directed load+shift_dec in the same cycle with A=0, B=9 -> A=9, P and Q unchanged. Then load+clear_c with A=0xF8, B=0x10 -> C=1, A=0x08.
